captura_operandos_alu: RTL

CAPTURA_OPERANDOS_ALU -- requirements
Module: captura_operandos_alu

---
 rtl/alu_pkg.sv | 21 ++
 rtl/sincronizador_flanco.sv | 32 +++
 rtl/captura_operandos_alu.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU operand-capture block: FSM state encoding and ALU opcodes.
package alu_pkg;

  typedef enum logic [2:0] {
    EsperaA  = 3'd0,
    EsperaB  = 3'd1,
    EsperaOp = 3'd2,
    Calculo  = 3'd3,
    Mostrar  = 3'd4
  } estado_t;

  localparam logic [2:0] OP_SUMA  = 3'b001;
  localparam logic [2:0] OP_RESTA = 3'b010;
  localparam logic [2:0] OP_AND   = 3'b011;
  localparam logic [2:0] OP_OR    = 3'b100;

  function automatic logic op_valido(input logic [2:0] op);
    return (op == OP_SUMA) || (op == OP_RESTA) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/sincronizador_flanco.sv
// Two-flop synchronizer plus rising-edge detector: one clk-wide pulse per button press.
module sincronizador_flanco (
  input  logic clk,
  input  logic reset_n,
  input  logic boton,
  output logic pulso
);

  logic sync1_q, sync2_q, prev_q;
  logic inic_q, armado_q;

  // armado only rises once a genuine low sample has been seen, so a button
  // already held at reset release cannot fire until it is released and pressed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      inic_q   <= 1'b0;
      armado_q <= 1'b0;
    end else begin
      sync1_q  <= boton;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      inic_q   <= 1'b1;
      armado_q <= armado_q | (inic_q & ~sync1_q);
    end
  end

  assign pulso = sync2_q & ~prev_q & armado_q;

endmodule

// File: rtl/captura_operandos_alu.sv
// Sequences operand A, operand B and opcode capture from switches, then latches the ALU result.
module captura_operandos_alu
  import alu_pkg::*;
#(
  parameter int unsigned n_bits = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [n_bits-1:0] dato_in,
  input  logic              boton_enter,
  input  logic              boton_cancelar,
  input  logic [n_bits-1:0] resultado_alu,
  output logic [n_bits-1:0] entrada_a,
  output logic [n_bits-1:0] entrada_b,
  output logic [2:0]        operacion,
  output logic [n_bits-1:0] resultado_reg,
  output logic              resultado_valido,
  output logic              error_op,
  output logic [2:0]        estado
);

  logic enter, cancel;

  sincronizador_flanco u_sync_enter (
    .clk     (clk),
    .reset_n (reset_n),
    .boton   (boton_enter),
    .pulso   (enter)
  );

  sincronizador_flanco u_sync_cancelar (
    .clk     (clk),
    .reset_n (reset_n),
    .boton   (boton_cancelar),
    .pulso   (cancel)
  );

  estado_t           state_q, state_d;
  logic [n_bits-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic              val_q, val_d, err_q, err_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    val_d   = val_q;
    err_d   = 1'b0;
    if (cancel) begin
      // Cancel overrides any enter pulse in the same cycle.
      state_d = EsperaA;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      res_d   = '0;
      val_d   = 1'b0;
    end else begin
      case (state_q)
        EsperaA: if (enter) begin
          a_d     = dato_in;
          state_d = EsperaB;
        end
        EsperaB: if (enter) begin
          b_d     = dato_in;
          state_d = EsperaOp;
        end
        EsperaOp: if (enter) begin
          if (op_valido(dato_in[2:0])) begin
            op_d    = dato_in[2:0];
            state_d = Calculo;
          end else begin
            err_d = 1'b1;
          end
        end
        Calculo: begin
          res_d   = resultado_alu;
          val_d   = 1'b1;
          state_d = Mostrar;
        end
        Mostrar: if (enter) begin
          val_d   = 1'b0;
          state_d = EsperaA;
        end
        default: state_d = EsperaA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EsperaA;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      val_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      val_q   <= val_d;
      err_q   <= err_d;
    end
  end

  assign entrada_a        = a_q;
  assign entrada_b        = b_q;
  assign operacion        = op_q;
  assign resultado_reg    = res_q;
  assign resultado_valido = val_q;
  assign error_op         = err_q;
  assign estado           = state_q;

endmodule
